// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if
//   Bundles the SPI pins and the backing-memory read port of the flash
//   responder.
//   master : drives the SPI pins (sck/ss/mosi) and the memory read data,
//            observes miso and the memory read request.
//   slave  : the responder itself.
//   Signals: spi_sck, spi_ss (active low), spi_mosi, spi_miso,
//            mem_ren (1-cycle strobe), mem_raddr (word address),
//            mem_rdata (valid one cycle after mem_ren).
interface spi_flash_responder_if;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_ren;
    logic [21:0] mem_raddr;
    logic [31:0] mem_rdata;

    modport master (
        output spi_sck, spi_ss, spi_mosi, mem_rdata,
        input  spi_miso, mem_ren, mem_raddr
    );

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, mem_rdata,
        output spi_miso, mem_ren, mem_raddr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI-flash responder (mode 0) that oversamples the SPI pins with the
//   system clock, decodes the READ command (opcode + 24-bit address) and
//   streams bytes MSB-first from a word-wide memory until chip select rises.
//   Ports:
//     clock, reset : system clock, synchronous active-high reset
//     bus (slave)  : SPI pins and backing-memory read port
//     busy         : synchronized chip select is asserted
//     cmd_err      : 1-cycle pulse when an unsupported opcode completes
module spi_flash_responder #(
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_flash_responder_if.slave bus,
    output logic                 busy,
    output logic                 cmd_err
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_FETCH, ST_DATA, ST_IGNORE
    } state_t;

    state_t state;

    // ---------------- pin synchronizers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic sck_s, ss_s, mosi_s;
    logic sck_d, ss_d;
    logic sck_rise, sck_fall, ss_deassert;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, whatever the
        // statement order.
        if (reset) begin
            // Synchronizers restart at the idle pin levels, so a reset with
            // chip select still low cannot fabricate edges on release.
            sck_sync    <= '0;
            ss_sync     <= '1;
            mosi_sync   <= '0;
            sck_d       <= 1'b0;
            ss_d        <= 1'b1;
            sck_rise    <= 1'b0;
            sck_fall    <= 1'b0;
            ss_deassert <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_d       <= sck_s;
            ss_d        <= ss_s;
            sck_rise    <= sck_s & ~sck_d;
            sck_fall    <= ~sck_s & sck_d;
            ss_deassert <= ss_s & ~ss_d;
        end
    end

    assign busy = ~ss_s;

    // ---------------- command / address / data engine ----------------
    logic [6:0]  op_shift;
    logic [4:0]  bit_cnt;
    logic [23:0] byte_addr;
    logic [31:0] word_buf;
    logic [31:0] next_buf;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_idx;
    logic        miso_q;
    logic        ren_q;
    logic        ren_d;
    logic [21:0] raddr_q;

    logic [7:0]  opcode_full;
    logic [23:0] addr_full;
    logic [1:0]  next_off;

    assign opcode_full = {op_shift, mosi_s};
    assign addr_full   = {byte_addr[22:0], mosi_s};
    assign next_off    = byte_addr[1:0] + 2'd1;

    assign bus.spi_miso  = miso_q;
    assign bus.mem_ren   = ren_q;
    assign bus.mem_raddr = raddr_q;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
        case (off)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_shift  <= '0;
            bit_cnt   <= '0;
            byte_addr <= '0;
            word_buf  <= '0;
            next_buf  <= '0;
            cur_byte  <= '0;
            bit_idx   <= '0;
            miso_q    <= 1'b0;
            ren_q     <= 1'b0;
            ren_d     <= 1'b0;
            raddr_q   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            // NOTE: strobes default low at the top of the clocked block so
            // each assertion below lasts exactly one cycle.
            ren_q   <= 1'b0;
            cmd_err <= 1'b0;
            ren_d   <= ren_q;
            // Every read returns here one cycle later; the fetch state also
            // takes its own copy, so only prefetched words matter in next_buf.
            if (ren_d) next_buf <= bus.mem_rdata;

            if (state != ST_IDLE && ss_deassert) begin
                state     <= ST_IDLE;
                op_shift  <= '0;
                bit_cnt   <= '0;
                byte_addr <= '0;
                bit_idx   <= '0;
                cur_byte  <= '0;
                miso_q    <= 1'b0;
                ren_d     <= 1'b0;  // drop a prefetch still in flight
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!ss_s) begin
                            state    <= ST_CMD;
                            bit_cnt  <= '0;
                            op_shift <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            op_shift <= opcode_full[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (opcode_full == READ_CMD) begin
                                    state <= ST_ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            byte_addr <= addr_full;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                ren_q   <= 1'b1;
                                raddr_q <= addr_full[23:2];
                                state   <= ST_FETCH;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        // The cycle with ren_q high is spent waiting; the
                        // data is on mem_rdata while ren_d is high.
                        if (ren_d) begin
                            word_buf <= bus.mem_rdata;
                            cur_byte <= pick_byte(bus.mem_rdata, byte_addr[1:0]);
                            bit_idx  <= '0;
                            state    <= ST_DATA;
                            if (byte_addr[1:0] == 2'd3) begin
                                ren_q   <= 1'b1;
                                raddr_q <= byte_addr[23:2] + 22'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall) begin
                            miso_q <= cur_byte[7];
                            if (bit_idx == 3'd7) begin
                                bit_idx   <= '0;
                                byte_addr <= byte_addr + 24'd1;
                                if (next_off == 2'd0) begin
                                    word_buf <= next_buf;
                                    cur_byte <= next_buf[7:0];
                                end else begin
                                    cur_byte <= pick_byte(word_buf, next_off);
                                end
                                // Last byte of the word selected: fetch the
                                // following word a full byte-time ahead.
                                if (next_off == 2'd3) begin
                                    ren_q   <= 1'b1;
                                    raddr_q <= byte_addr[23:2] + 22'd1;
                                end
                            end else begin
                                bit_idx  <= bit_idx + 3'd1;
                                cur_byte <= {cur_byte[6:0], 1'b0};
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_q <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
